// File: rtl/game_logic.sv
// game_logic: controller for the letter-guessing word game.
// It latches a 5-letter word and sweeps each new guess across the five letter positions.
// It tracks revealed positions, the correct count and the mistake count.
// The game ends when all 5 letters are revealed or after 6 mistakes.
module game_logic #(
   parameter int unsigned RED_CYCLES = 8
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic [39:0] setWord,
   input  logic [7:0]  guess,
   input  logic        toggle_state,
   output logic [7:0]  letter,
   output logic        green,
   output logic        red,
   output logic        red_busy,
   output logic        mistake,
   output logic        game_rdy,
   output logic [2:0]  incorrect,
   output logic [2:0]  correct,
   output logic [4:0]  indexCorrect,
   output logic        gameEnd
);

   localparam int unsigned WORD_W = 40;
   localparam int unsigned CHAR_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned POS_N  = 5;
   localparam int unsigned RED_W  = 4;
   localparam logic [CNT_W-1:0] MAX_CORRECT   = CNT_W'(5);
   localparam logic [CNT_W-1:0] MAX_INCORRECT = CNT_W'(6);

   typedef enum logic [2:0] {
      SET  = 3'd0,
      L0   = 3'd1,
      L1   = 3'd2,
      L2   = 3'd3,
      L3   = 3'd4,
      L4   = 3'd5,
      STOP = 3'd6,
      IDLE = 3'd7
   } state_t;

   state_t              state, state_nx;
   logic [WORD_W-1:0]   word, word_nx;
   logic [CHAR_W-1:0]   last_guess, last_nx;
   logic                hit, hit_nx;
   logic [POS_N-1:0]    idx_nx;
   logic [CNT_W-1:0]    corr_nx, inc_nx;
   logic                green_nx, mistake_nx;
   logic [RED_W-1:0]    red_cnt, red_cnt_nx;
   logic [CHAR_W-1:0]   cur_byte, letter_nx;
   logic [POS_N-1:0]    cur_mask;

   // Word byte compared in a given sweep state (zero outside the sweep)
   function automatic logic [CHAR_W-1:0] byte_at(input state_t s, input logic [WORD_W-1:0] w);
      logic [CHAR_W-1:0] b;
      case (s)
         L0:      b = w[7:0];
         L1:      b = w[15:8];
         L2:      b = w[23:16];
         L3:      b = w[31:24];
         L4:      b = w[39:32];
         default: b = '0;
      endcase
      return b;
   endfunction

   // One-hot position mask for a given sweep state
   function automatic logic [POS_N-1:0] mask_at(input state_t s);
      logic [POS_N-1:0] m;
      case (s)
         L0:      m = 5'b00001;
         L1:      m = 5'b00010;
         L2:      m = 5'b00100;
         L3:      m = 5'b01000;
         L4:      m = 5'b10000;
         default: m = '0;
      endcase
      return m;
   endfunction

   // State register
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state <= SET;
      else       state <= state_nx;
   end

   // Next-state and next datapath values
   always_comb begin
      state_nx   = state;
      word_nx    = word;
      last_nx    = last_guess;
      hit_nx     = hit;
      idx_nx     = indexCorrect;
      corr_nx    = correct;
      inc_nx     = incorrect;
      green_nx   = green;
      mistake_nx = 1'b0;
      red_cnt_nx = (red_cnt != '0) ? red_cnt - RED_W'(1) : '0;
      cur_byte   = byte_at(state, word);
      cur_mask   = mask_at(state);

      case (state)
         SET: begin
            if (toggle_state) begin
               word_nx  = setWord;
               state_nx = IDLE;
            end
         end
         IDLE: begin
            if (!red_busy && guess != '0 && guess != last_guess) begin
               last_nx  = guess;
               hit_nx   = 1'b0;
               state_nx = L0;
            end
         end
         L0, L1, L2, L3, L4: begin
            if (guess == cur_byte) begin
               hit_nx = 1'b1;
               if ((indexCorrect & cur_mask) == '0) begin
                  idx_nx  = indexCorrect | cur_mask;
                  corr_nx = correct + CNT_W'(1);
               end
            end
            case (state)
               L0:      state_nx = L1;
               L1:      state_nx = L2;
               L2:      state_nx = L3;
               L3:      state_nx = L4;
               default: begin
                  // End of sweep: verdict uses this cycle's updates
                  if (hit_nx) begin
                     green_nx = 1'b1;
                  end else begin
                     green_nx   = 1'b0;
                     inc_nx     = (incorrect >= MAX_INCORRECT) ? MAX_INCORRECT : incorrect + CNT_W'(1);
                     mistake_nx = 1'b1;
                     red_cnt_nx = RED_W'(RED_CYCLES);
                  end
                  state_nx = (corr_nx == MAX_CORRECT || inc_nx == MAX_INCORRECT) ? STOP : IDLE;
               end
            endcase
         end
         STOP: begin
            if (toggle_state) begin
               word_nx  = '0;
               last_nx  = '0;
               hit_nx   = 1'b0;
               idx_nx   = '0;
               corr_nx  = '0;
               inc_nx   = '0;
               green_nx = 1'b0;
               state_nx = SET;
            end
         end
         default: state_nx = SET;
      endcase

      letter_nx = byte_at(state_nx, word_nx);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         word         <= '0;
         last_guess   <= '0;
         hit          <= 1'b0;
         indexCorrect <= '0;
         correct      <= '0;
         incorrect    <= '0;
         green        <= 1'b0;
         mistake      <= 1'b0;
         red_cnt      <= '0;
         red          <= 1'b0;
         red_busy     <= 1'b0;
         letter       <= '0;
         game_rdy     <= 1'b0;
         gameEnd      <= 1'b0;
      end else begin
         word         <= word_nx;
         last_guess   <= last_nx;
         hit          <= hit_nx;
         indexCorrect <= idx_nx;
         correct      <= corr_nx;
         incorrect    <= inc_nx;
         green        <= green_nx;
         mistake      <= mistake_nx;
         red_cnt      <= red_cnt_nx;
         red          <= (red_cnt_nx != '0);
         red_busy     <= (red_cnt_nx != '0);
         letter       <= letter_nx;
         game_rdy     <= (state_nx == IDLE);
         gameEnd      <= (state_nx == STOP);
      end
   end

endmodule

// File: tb/tb_game_logic.sv
// tb_game_logic: scoreboard bench for game_logic with a word-level reference model.
module tb_game_logic;

   localparam int unsigned RED_CYCLES = 8;

   logic        clk = 1'b0;
   logic        nRst;
   logic [39:0] setWord;
   logic [7:0]  guess;
   logic        toggle_state;
   logic [7:0]  letter;
   logic        green, red, red_busy, mistake, game_rdy, gameEnd;
   logic [2:0]  incorrect, correct;
   logic [4:0]  indexCorrect;

   game_logic #(.RED_CYCLES(RED_CYCLES)) dut (
      .clk(clk), .nRst(nRst), .setWord(setWord), .guess(guess), .toggle_state(toggle_state),
      .letter(letter), .green(green), .red(red), .red_busy(red_busy), .mistake(mistake),
      .game_rdy(game_rdy), .incorrect(incorrect), .correct(correct),
      .indexCorrect(indexCorrect), .gameEnd(gameEnd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] correct;
      logic [2:0] incorrect;
      logic [4:0] idx;
      logic       green;
      logic       miss;
      logic       gend;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_en   = 1'b0;

   // Reference model state: the word as five letters, revealed flags, counts
   logic [7:0] m_w[5];
   logic [4:0] m_rev;
   int         m_corr, m_inc;
   logic [7:0] m_last;
   bit         m_end;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   task automatic model_reset();
      m_rev = '0; m_corr = 0; m_inc = 0; m_last = '0; m_end = 1'b0;
   endtask

   task automatic model_load(input logic [39:0] w);
      for (int i = 0; i < 5; i++) m_w[i] = w[8*i +: 8];
   endtask

   // Word-level judgement of one guess
   task automatic model_eval(input logic [7:0] g);
      exp_t e;
      bit any = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (m_w[i] == g) begin
            any = 1'b1;
            if (!m_rev[i]) begin m_rev[i] = 1'b1; m_corr++; end
         end
      end
      if (!any && m_inc < 6) m_inc++;
      m_last = g;
      m_end  = (m_corr == 5) || (m_inc == 6);
      e.correct = 3'(m_corr); e.incorrect = 3'(m_inc); e.idx = m_rev;
      e.green = any; e.miss = !any; e.gend = m_end;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 300; i++) begin
         if (game_rdy && !red_busy) return;
         @(posedge clk); #1;
      end
      chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic [7:0] g, input int hold);
      wait_ready();
      guess = g;
      if (!m_end && g != 8'h00 && g != m_last) model_eval(g);
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic start_game(input logic [39:0] w);
      bit ok = 1'b0;
      guess = 8'h00;
      setWord = w;
      toggle_state = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         ok = game_rdy;
      end
      toggle_state = 1'b0;
      chk("start_rdy", 32'(ok), 32'd1);
      chk("start_correct", 32'(correct), 32'd0);
      chk("start_incorrect", 32'(incorrect), 32'd0);
      chk("start_index", 32'(indexCorrect), 32'd0);
      model_reset();
      model_load(w);
   endtask

   task automatic hard_reset();
      nRst = 1'b0;
      @(posedge clk); #1;
      nRst = 1'b1;
      @(posedge clk); #1;
      model_reset();
   endtask

   // Monitor: an evaluation completes when letter returns to 0 after the sweep
   logic [7:0] prev_letter = '0;
   logic       prev_mistake = 1'b0;
   int         red_len = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!nRst) begin
         prev_letter = '0; prev_mistake = 1'b0; red_len = 0;
      end else begin
         if (mon_en && prev_letter != 8'h00 && letter == 8'h00) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_eval", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("correct", 32'(correct), 32'(e.correct));
               chk("incorrect", 32'(incorrect), 32'(e.incorrect));
               chk("indexCorrect", 32'(indexCorrect), 32'(e.idx));
               chk("green", 32'(green), 32'(e.green));
               chk("mistake", 32'(mistake), 32'(e.miss));
               chk("red", 32'(red), 32'(e.miss));
               chk("gameEnd", 32'(gameEnd), 32'(e.gend));
            end
         end
         if (mon_en && prev_mistake) chk("mistake_width", 32'(mistake), 32'd0);
         if (red) red_len++;
         else if (red_len != 0) begin
            if (mon_en) chk("red_len", 32'(red_len), 32'(RED_CYCLES));
            red_len = 0;
         end
         if (mon_en && red != red_busy) chk("red_busy", 32'(red_busy), 32'(red));
         prev_letter  = letter;
         prev_mistake = mistake;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] w;
      int          r;
      nRst = 1'b0; toggle_state = 1'b1; guess = 8'h00; setWord = 40'h4150504C45;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {letter, green, red, red_busy, mistake, game_rdy, incorrect, correct,
                          indexCorrect, gameEnd}, 32'd0);
      toggle_state = 1'b0;
      nRst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stay_set", {30'd0, game_rdy, gameEnd}, 32'd0);
      chk("rst_counters", {26'd0, correct, incorrect}, 32'd0);

      mon_en = 1'b1;

      // Six misses on APPLE
      start_game(40'h4150504C45);
      issue("C", 25); issue("J", 25); issue("Q", 25);
      issue("R", 25); issue("K", 25); issue("M", 25);
      chk("g2_gameEnd", 32'(gameEnd), 32'd1);
      chk("g2_incorrect", 32'(incorrect), 32'd6);
      chk("g2_correct", 32'(correct), 32'd0);

      // Full reveal of APPLE, restarting from STOP
      start_game(40'h4150504C45);
      issue("A", 25); issue("P", 25); issue("L", 25); issue("E", 25);
      chk("g3_index", 32'(indexCorrect), 32'h1F);
      chk("g3_green", 32'(green), 32'd1);
      chk("g3_gameEnd", 32'(gameEnd), 32'd1);

      // MOORE: hit then miss
      start_game(40'h4D4F4F5245);
      issue("M", 25); issue("A", 25);
      chk("g4_correct", 32'(correct), 32'd1);
      hard_reset();

      // Held guess evaluated once; repeat after an intervening guess
      start_game(40'h4150504C45);
      issue("C", 100); issue("A", 25); issue("P", 25); issue("A", 25);
      chk("g5_incorrect", 32'(incorrect), 32'd1);
      chk("g5_correct", 32'(correct), 32'd3);
      chk("g5_green", 32'(green), 32'd1);

      // Reset in the middle of a sweep
      hard_reset();
      start_game(40'h4150504C45);
      mon_en = 1'b0;
      wait_ready();
      guess = "A";
      repeat (3) @(posedge clk);
      #1;
      nRst = 1'b0;
      #2;
      chk("midrst_outputs", {letter, green, red, mistake, game_rdy, incorrect, correct,
                             indexCorrect, gameEnd}, 32'd0);
      guess = 8'h00;
      @(posedge clk); #1;
      nRst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_set", {30'd0, game_rdy, gameEnd}, 32'd0);
      chk("midrst_counters", {21'd0, correct, incorrect, indexCorrect}, 32'd0);
      model_reset();
      mon_en = 1'b1;

      // Random games over a small alphabet so hits and repeats are common
      for (int gm = 0; gm < 12; gm++) begin
         for (int i = 0; i < 5; i++) w[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 7));
         start_game(w);
         for (int k = 0; k < 40 && !m_end; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      issue(8'h00, 8);
            else if (r == 1) issue(m_last == 8'h00 ? 8'h41 : m_last, 8);
            else             issue(8'h41 + 8'($urandom_range(0, 9)), 8 + int'($urandom_range(0, 4)));
         end
         if (!m_end) begin
            wait_ready();
            hard_reset();
         end
      end

      repeat (20) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
